mov_seq_gen: RTL

- Inverse of the MOVZ/MOVK datapath: takes a 64-bit constant plus a destination register and emits the shortest MOVZ/MOVK sequence (1–4 instructions, 32-bit LEGv8 IW format) that rebuilds the constant.
- Sits between the test-program/constant loader and the instruction-memory write port, or a micro-op injector.
- Valid/ready handshake on the command side and on the instruction side.

---
 rtl/mov_seq_pkg.sv | 38 +++
 rtl/mov_seq_gen_halfword_pick.sv | 22 ++
 rtl/mov_seq_gen.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/mov_seq_pkg.sv
// Shared types and constants for the MOVZ/MOVK/MOVN sequence generator.
// Encoding helpers follow the LEGv8 IW format: opcode, hw shift, imm16, Rd.
package mov_seq_pkg;

  localparam int IW_RD_W  = 5;
  localparam int IW_IMM_W = 16;

  localparam logic [8:0] OPC_MOVZ = 9'b110100101;
  localparam logic [8:0] OPC_MOVK = 9'b111100101;
  localparam logic [8:0] OPC_MOVN = 9'b100100101;

  localparam int OPC_LSB = 23;
  localparam int HW_LSB  = 21;
  localparam int IMM_LSB = 5;
  localparam int RD_LSB  = 0;

  typedef enum logic {
    IDLE,
    EMIT
  } state_t;

  typedef struct packed {
    logic [8:0]          opcode;
    logic [1:0]          hw;
    logic [IW_IMM_W-1:0] imm;
    logic [IW_RD_W-1:0]  rd;
  } iw_instr_t;

  function automatic logic [31:0] encode(input iw_instr_t f);
    return (32'(f.opcode) << OPC_LSB) | (32'(f.hw) << HW_LSB) |
           (32'(f.imm) << IMM_LSB) | (32'(f.rd) << RD_LSB);
  endfunction

  function automatic logic [2:0] popcount4(input logic [3:0] m);
    return 3'(m[0]) + 3'(m[1]) + 3'(m[2]) + 3'(m[3]);
  endfunction

endpackage

// File: rtl/mov_seq_gen_halfword_pick.sv
// Finds the lowest set mask bit strictly above the current halfword index.
// Reports none_left when no such bit exists (index output is then 0).
module halfword_pick (
  input  logic [3:0] mask,
  input  logic [1:0] cur,
  output logic [1:0] next_idx,
  output logic       none_left
);

  // Scanning downward lets the lowest qualifying bit win.
  always_comb begin
    next_idx  = 2'd0;
    none_left = 1'b1;
    for (int i = 3; i >= 0; i--) begin
      if (i > int'(cur) && mask[i]) begin
        next_idx  = 2'(i);
        none_left = 1'b0;
      end
    end
  end

endmodule

// File: rtl/mov_seq_gen.sv
// Emits the shortest MOVZ/MOVK sequence that rebuilds a 64-bit constant.
// Define MOV_SEQ_MOVN_EN to start with MOVN when FFFF halfwords dominate.
module mov_seq_gen
  import mov_seq_pkg::*;
#(
  parameter int RD_W  = 5,
  parameter int IMM_W = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [63:0]     in_value,
  input  logic [RD_W-1:0] in_rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic            out_last,
  output logic            busy
);

  localparam int HW_N = 64 / IMM_W;

  typedef logic [HW_N-1:0][IMM_W-1:0] hw_vec_t;

  state_t          state, state_nx;
  hw_vec_t         in_hw, value_q;
  logic [RD_W-1:0] rd_q;
  logic [HW_N-1:0] nz_mask, cap_mask, emit_mask_q, rem_q, first_rem, adv_rem;
  logic [1:0]      cur_q, first_idx, pick0_idx, adv_idx;
  logic            pick0_none, adv_none;
  logic            use_movn, load_first, advance, finish;
  iw_instr_t       first_f, adv_f;

  assign in_hw = in_value;

  always_comb begin
    nz_mask = '0;
    for (int i = 0; i < HW_N; i++) nz_mask[i] = (in_hw[i] != '0);
  end

`ifdef MOV_SEQ_MOVN_EN
  logic [HW_N-1:0] ones_mask;

  // MOVN only pays off when all-ones halfwords strictly outnumber zero ones.
  always_comb begin
    ones_mask = '0;
    for (int i = 0; i < HW_N; i++) ones_mask[i] = (in_hw[i] == '1);
    use_movn = popcount4(ones_mask) > popcount4(~nz_mask);
  end

  assign cap_mask = use_movn ? ~ones_mask : nz_mask;
`else
  assign use_movn = 1'b0;
  assign cap_mask = nz_mask;
`endif

  halfword_pick u_pick_first (
    .mask      (cap_mask),
    .cur       (2'd0),
    .next_idx  (pick0_idx),
    .none_left (pick0_none)
  );

  halfword_pick u_pick_adv (
    .mask      (emit_mask_q),
    .cur       (cur_q),
    .next_idx  (adv_idx),
    .none_left (adv_none)
  );

  // An empty mask falls back to halfword 0, whose imm is then 0 either way.
  assign first_idx = (cap_mask[0] || pick0_none) ? 2'd0 : pick0_idx;
  assign first_rem = cap_mask & ~(HW_N'(1) << first_idx);
  assign adv_rem   = rem_q & ~(HW_N'(1) << adv_idx);

  always_comb begin
    first_f.opcode = use_movn ? OPC_MOVN : OPC_MOVZ;
    first_f.hw     = first_idx;
    first_f.imm    = use_movn ? IW_IMM_W'(~in_hw[first_idx]) : IW_IMM_W'(in_hw[first_idx]);
    first_f.rd     = IW_RD_W'(in_rd);
    adv_f.opcode   = OPC_MOVK;
    adv_f.hw       = adv_idx;
    adv_f.imm      = IW_IMM_W'(value_q[adv_idx]);
    adv_f.rd       = IW_RD_W'(rd_q);
  end

  always_comb begin
    state_nx   = state;
    load_first = 1'b0;
    advance    = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          state_nx   = EMIT;
          load_first = 1'b1;
        end
      end
      EMIT: begin
        if (out_valid && out_ready) begin
          if (out_last || adv_none) begin
            state_nx = IDLE;
            finish   = 1'b1;
          end else begin
            advance = 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign in_ready = (state == IDLE);
  assign busy     = (state == EMIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Output registers only change on capture or on an accepted instruction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value_q     <= '0;
      rd_q        <= '0;
      emit_mask_q <= '0;
      rem_q       <= '0;
      cur_q       <= '0;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      out_instr   <= '0;
    end else if (load_first) begin
      value_q     <= in_hw;
      rd_q        <= in_rd;
      emit_mask_q <= cap_mask;
      rem_q       <= first_rem;
      cur_q       <= first_idx;
      out_valid   <= 1'b1;
      out_last    <= (first_rem == '0);
      out_instr   <= encode(first_f);
    end else if (advance) begin
      rem_q     <= adv_rem;
      cur_q     <= adv_idx;
      out_last  <= (adv_rem == '0);
      out_instr <= encode(adv_f);
    end else if (finish) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

endmodule
